// File: rtl/freq_pkg.sv
// Shared definitions for the frequency counter and its transmit-side pulse generator.
package freq_pkg;

    localparam int CNT_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0] on;
        logic [CNT_W-1:0] off;
    } cfg_t;

endpackage

// File: rtl/cfg_slot.sv
// One-entry pending configuration register with valid/ready intake and an apply/clear input.
module cfg_slot #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    output logic         ready,
    input  logic [W-1:0] on_in,
    input  logic [W-1:0] off_in,
    input  logic         apply,
    output logic         pv,
    output logic [W-1:0] on_p,
    output logic [W-1:0] off_p
);

    logic         pv_q, pv_d;
    logic [W-1:0] on_q, on_d, off_q, off_d;

    assign ready = ~pv_q;
    assign pv    = pv_q;
    assign on_p  = on_q;
    assign off_p = off_q;

    // apply only happens with pv_q set, so it never coincides with an intake
    always_comb begin
        pv_d  = pv_q;
        on_d  = on_q;
        off_d = off_q;
        if (apply)
            pv_d = 1'b0;
        if (valid && ready) begin
            pv_d  = 1'b1;
            on_d  = on_in;
            off_d = off_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q  <= 1'b0;
            on_q  <= '0;
            off_q <= '0;
        end else begin
            pv_q  <= pv_d;
            on_q  <= on_d;
            off_q <= off_d;
        end
    end

endmodule

// File: rtl/pulse_generator.sv
// Programmable square-wave / PWM source: ON_CYC high cycles, OFF_CYC low cycles, config applied at period boundaries.
module pulse_generator
    import freq_pkg::*;
#(
    parameter int W  = CNT_W,
    parameter int PW = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          EN,
    input  logic          CFG_VALID,
    output logic          CFG_READY,
    input  logic [W-1:0]  CFG_ON,
    input  logic [W-1:0]  CFG_OFF,
    output logic          OUT,
    output logic          BUSY,
    output logic          PERIOD_DONE,
    output logic [PW-1:0] PERIOD_CNT
);

    state_t        state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  on_a_q, on_a_d, off_a_q, off_a_d;
    logic          out_q, out_d;
    logic [PW-1:0] pcnt_q, pcnt_d;

    logic          pv, apply, boundary, start;
    logic [W-1:0]  on_p, off_p, nxt_on, nxt_off;

    cfg_slot #(.W(W)) u_slot (
        .clk    (CLK),
        .rst_n  (RST_N),
        .valid  (CFG_VALID),
        .ready  (CFG_READY),
        .on_in  (CFG_ON),
        .off_in (CFG_OFF),
        .apply  (apply),
        .pv     (pv),
        .on_p   (on_p),
        .off_p  (off_p)
    );

    always_comb begin
        boundary = ((state_q == HIGH) && (cnt_q == on_a_q) && (off_a_q == '0)) ||
                   ((state_q == LOW) && (cnt_q == off_a_q));
        apply    = pv && (boundary || (state_q == IDLE));
        nxt_on   = apply ? on_p  : on_a_q;
        nxt_off  = apply ? off_p : off_a_q;
        start    = EN && ((nxt_on != '0) || (nxt_off != '0));

        state_d  = state_q;
        cnt_d    = cnt_q;
        on_a_d   = nxt_on;
        off_a_d  = nxt_off;
        pcnt_d   = pcnt_q;
        if (boundary)
            pcnt_d = pcnt_q + PW'(1);

        // IDLE starts from the config that is active after this edge, same as a boundary
        if ((state_q == IDLE) || boundary) begin
            if (start) begin
                state_d = (nxt_on != '0) ? HIGH : LOW;
                cnt_d   = W'(1);
            end else begin
                state_d = IDLE;
            end
        end else if ((state_q == HIGH) && (cnt_q == on_a_q)) begin
            state_d = LOW;
            cnt_d   = W'(1);
        end else if ((state_q == HIGH) || (state_q == LOW)) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            state_d = IDLE;
        end

        out_d = (state_d == HIGH);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            on_a_q  <= '0;
            off_a_q <= '0;
            out_q   <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            on_a_q  <= on_a_d;
            off_a_q <= off_a_d;
            out_q   <= out_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign OUT         = out_q;
    assign BUSY        = (state_q != IDLE);
    assign PERIOD_DONE = boundary;
    assign PERIOD_CNT  = pcnt_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Self-checking bench: table of configs checked against a period-formula scoreboard, plus update/EN-drop/reset sequences.
module tb_pulse_generator;
    import freq_pkg::*;

    localparam int W  = 12;
    localparam int PW = 16;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          EN = 1'b0;
    logic          CFG_VALID = 1'b0;
    logic [W-1:0]  CFG_ON = '0;
    logic [W-1:0]  CFG_OFF = '0;
    logic          CFG_READY, OUT, BUSY, PERIOD_DONE;
    logic [PW-1:0] PERIOD_CNT;

    pulse_generator #(.W(W), .PW(PW)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .EN          (EN),
        .CFG_VALID   (CFG_VALID),
        .CFG_READY   (CFG_READY),
        .CFG_ON      (CFG_ON),
        .CFG_OFF     (CFG_OFF),
        .OUT         (OUT),
        .BUSY        (BUSY),
        .PERIOD_DONE (PERIOD_DONE),
        .PERIOD_CNT  (PERIOD_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic          out;
        logic          done;
        logic          busy;
        logic [PW-1:0] pcnt;
    } exp_t;

    typedef struct {
        cfg_t cfg;
        int   cycles;
    } vec_t;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_fail = 0;
    logic [PW-1:0] exp_pcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Expected waveform of one period, derived from the period shape alone
    task automatic push_period(input int on, input int off);
        exp_t e;
        int   p;
        p = on + off;
        for (int i = 0; i < p; i++) begin
            e.out  = (i < on);
            e.done = (i == p - 1);
            e.busy = 1'b1;
            e.pcnt = exp_pcnt;
            sb.push_back(e);
        end
        exp_pcnt = exp_pcnt + 1'b1;
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.out  = 1'b0;
            e.done = 1'b0;
            e.busy = 1'b0;
            e.pcnt = exp_pcnt;
            sb.push_back(e);
        end
    endtask

    task automatic step_check(input string tag);
        exp_t e;
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_sb: got empty scoreboard expected an entry at %0t", tag, $time);
        end else begin
            e = sb.pop_front();
            check({tag, "_out"},  OUT,         e.out);
            check({tag, "_done"}, PERIOD_DONE, e.done);
            check({tag, "_busy"}, BUSY,        e.busy);
            check({tag, "_pcnt"}, PERIOD_CNT,  e.pcnt);
        end
    endtask

    task automatic reset_dut();
        RST_N     = 1'b0;
        EN        = 1'b0;
        CFG_VALID = 1'b0;
        #3;
        check("rst_out",   OUT,         1'b0);
        check("rst_busy",  BUSY,        1'b0);
        check("rst_done",  PERIOD_DONE, 1'b0);
        check("rst_pcnt",  PERIOD_CNT,  '0);
        check("rst_ready", CFG_READY,   1'b1);
        @(negedge CLK);
        RST_N    = 1'b1;
        exp_pcnt = '0;
        sb.delete();
    endtask

    // Word accepted on the next edge; the following edge applies it and starts
    task automatic start_cfg(input int on, input int off);
        EN        = 1'b1;
        CFG_VALID = 1'b1;
        CFG_ON    = W'(on);
        CFG_OFF   = W'(off);
        @(posedge CLK);
        #1;
        check("accept_ready", CFG_READY, 1'b0);
        check("accept_busy",  BUSY,      1'b0);
        CFG_VALID = 1'b0;
    endtask

    function automatic vec_t mk(input int on, input int off, input int cyc);
        vec_t v;
        v.cfg.on  = W'(on);
        v.cfg.off = W'(off);
        v.cycles  = cyc;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        vt[0] = mk(3, 2, 22);
        vt[1] = mk(1, 1, 10);
        vt[2] = mk(0, 5, 16);
        vt[3] = mk(5, 0, 16);
        vt[4] = mk(0, 0, 10);
        vt[5] = mk(100, 37, 300);
        vt[6] = mk(4095, 1, 4100);

        foreach (vt[i]) begin
            reset_dut();
            start_cfg(int'(vt[i].cfg.on), int'(vt[i].cfg.off));
            if (vt[i].cfg.on == '0 && vt[i].cfg.off == '0)
                push_idle(vt[i].cycles);
            else
                while (sb.size() < vt[i].cycles)
                    push_period(int'(vt[i].cfg.on), int'(vt[i].cfg.off));
            for (int k = 0; k < vt[i].cycles; k++) begin
                step_check("vec");
                if (k == 0)
                    check("vec_ready_applied", CFG_READY, 1'b1);
            end
        end

        // Mid-run update with a second word stalled while the slot is full
        reset_dut();
        start_cfg(4, 4);
        push_period(4, 4);
        push_period(2, 6);
        repeat (3) push_period(3, 1);
        for (int k = 0; k < 28; k++) begin
            step_check("upd");
            check("upd_ready", CFG_READY, !((k >= 2 && k <= 7) || (k >= 9 && k <= 15)));
            if (k == 1) begin
                CFG_VALID = 1'b1;
                CFG_ON    = W'(2);
                CFG_OFF   = W'(6);
            end
            if (k == 2) begin
                CFG_ON  = W'(3);
                CFG_OFF = W'(1);
            end
            if (k == 9)
                CFG_VALID = 1'b0;
        end

        // EN dropped in the second HIGH cycle: period completes, then idle
        reset_dut();
        start_cfg(3, 3);
        push_period(3, 3);
        push_idle(4);
        for (int k = 0; k < 10; k++) begin
            step_check("endrop");
            if (k == 1)
                EN = 1'b0;
        end

        // Reset between edges while HIGH in the second period
        reset_dut();
        start_cfg(3, 3);
        push_period(3, 3);
        push_period(3, 3);
        for (int k = 0; k < 8; k++)
            step_check("prerst");
        #2;
        RST_N = 1'b0;
        #1;
        check("rstmid_out",   OUT,         1'b0);
        check("rstmid_busy",  BUSY,        1'b0);
        check("rstmid_done",  PERIOD_DONE, 1'b0);
        check("rstmid_pcnt",  PERIOD_CNT,  '0);
        check("rstmid_ready", CFG_READY,   1'b1);
        sb.delete();
        @(negedge CLK);
        RST_N    = 1'b1;
        exp_pcnt = '0;
        push_idle(4);
        for (int k = 0; k < 4; k++)
            step_check("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
